// File: rtl/lcd_power_sequencer_if.sv
// ----------------------------------------------------------------------------
// lcd_power_sequencer_if
//
// Purpose: bundles the board-control inputs and the panel power outputs of the
// LCD power sequencer into a single port.
//
// Signals:
//   enable        board -> seq : level request for panel on
//   fault         board -> seq : level, emergency shutdown while high
//   frame_start   board -> seq : one-cycle pulse at start of frame
//   panel_vdd_en  seq -> board : panel logic supply enable
//   lvds_en       seq -> board : serializer / clock-pair enable
//   blank         seq -> board : force black data, DE low
//   backlight_en  seq -> board : backlight enable
//   ready         seq -> board : high only while the panel is running
//   err           seq -> board : sticky frame-sync timeout flag
//   state         seq -> board : current state encoding (debug)
//
// Modports:
//   master : board-control side (drives requests, observes outputs)
//   slave  : sequencer side
// ----------------------------------------------------------------------------
interface lcd_power_sequencer_if;
   logic       enable;
   logic       fault;
   logic       frame_start;
   logic       panel_vdd_en;
   logic       lvds_en;
   logic       blank;
   logic       backlight_en;
   logic       ready;
   logic       err;
   logic [2:0] state;

   modport master (
      output enable, fault, frame_start,
      input  panel_vdd_en, lvds_en, blank, backlight_en, ready, err, state
   );

   modport slave (
      input  enable, fault, frame_start,
      output panel_vdd_en, lvds_en, blank, backlight_en, ready, err, state
   );
endinterface

// File: rtl/lcd_power_sequencer.sv
// ----------------------------------------------------------------------------
// lcd_power_sequencer
//
// Purpose: sequences LVDS LCD panel power-up / power-down. Raises panel VDD,
// then the LVDS serializer, waits for a frame boundary, then unblanks and turns
// the backlight on. Power-down runs the reverse order and ends with a
// mandatory VDD-off cool-down before the panel may be re-powered.
//
// Ports:
//   clk    : system clock (same as the bit clock domain)
//   rst_n  : asynchronous active-low reset
//   bus    : lcd_power_sequencer_if.slave (enable/fault/frame_start in,
//            panel_vdd_en/lvds_en/blank/backlight_en/ready/err/state out)
//
// Parameters: T_VDD, T_LVDS, T_BL, T_LOFF, T_COOL, SYNC_TO are durations in
// clk cycles (each >= 1 and < 2^CW).
// ----------------------------------------------------------------------------
module lcd_power_sequencer #(
   parameter int T_VDD   = 2048,
   parameter int T_LVDS  = 4096,
   parameter int T_BL    = 2048,
   parameter int T_LOFF  = 2048,
   parameter int T_COOL  = 8192,
   parameter int SYNC_TO = 65536,
   parameter int CW      = 17
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lcd_power_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_PWR_UP    = 3'd1,
      S_LVDS_UP   = 3'd2,
      S_SYNC      = 3'd3,
      S_RUN       = 3'd4,
      S_BL_DOWN   = 3'd5,
      S_LVDS_DOWN = 3'd6,
      S_COOL      = 3'd7
   } state_t;

   // Counter load values: a state of duration P starts at P-1 and exits when
   // the counter reads zero, giving exactly P cycles of residence.
   localparam logic [CW-1:0] LD_VDD  = CW'(T_VDD - 1);
   localparam logic [CW-1:0] LD_LVDS = CW'(T_LVDS - 1);
   localparam logic [CW-1:0] LD_SYNC = CW'(SYNC_TO - 1);
   localparam logic [CW-1:0] LD_BL   = CW'(T_BL - 1);
   localparam logic [CW-1:0] LD_LOFF = CW'(T_LOFF - 1);
   localparam logic [CW-1:0] LD_COOL = CW'(T_COOL - 1);

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          err_reg, err_next;
   logic          vdd_reg, vdd_next;
   logic          lvds_reg, lvds_next;
   logic          blank_reg, blank_next;
   logic          bl_reg, bl_next;
   logic          ready_reg, ready_next;
   logic          cnt_zero;

   assign cnt_zero = (cnt_reg == '0);

   // ------------------------------------------------------------------
   // State register (state, delay counter, sticky error, outputs)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_OFF;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
         vdd_reg   <= 1'b0;
         lvds_reg  <= 1'b0;
         blank_reg <= 1'b1;
         bl_reg    <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
         vdd_reg   <= vdd_next;
         lvds_reg  <= lvds_next;
         blank_reg <= blank_next;
         bl_reg    <= bl_next;
         ready_reg <= ready_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic, including counter reload and the sticky error
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      err_next   = err_reg;

      // Fault overrides everything except the states that already have VDD off.
      if (bus.fault && (state_reg != S_OFF) && (state_reg != S_COOL)) begin
         state_next = S_COOL;
      end else begin
         case (state_reg)
            S_OFF: begin
               if (bus.enable && !bus.fault) begin
                  state_next = S_PWR_UP;
                  err_next   = 1'b0;
               end
            end
            S_PWR_UP: begin
               if (!bus.enable)   state_next = S_LVDS_DOWN;
               else if (cnt_zero) state_next = S_LVDS_UP;
            end
            S_LVDS_UP: begin
               if (!bus.enable)   state_next = S_LVDS_DOWN;
               else if (cnt_zero) state_next = S_SYNC;
            end
            S_SYNC: begin
               // A frame_start coinciding with the timeout still counts as sync.
               if (!bus.enable) begin
                  state_next = S_LVDS_DOWN;
               end else if (bus.frame_start) begin
                  state_next = S_RUN;
               end else if (cnt_zero) begin
                  state_next = S_LVDS_DOWN;
                  err_next   = 1'b1;
               end
            end
            S_RUN: begin
               if (!bus.enable) state_next = S_BL_DOWN;
            end
            // The power-down leg ignores enable so it always runs to completion.
            S_BL_DOWN:   if (cnt_zero) state_next = S_LVDS_DOWN;
            S_LVDS_DOWN: if (cnt_zero) state_next = S_COOL;
            S_COOL:      if (cnt_zero) state_next = S_OFF;
            default:     state_next = S_OFF;
         endcase
      end

      // Reload on every state change; otherwise count down and hold at zero.
      cnt_next = cnt_reg;
      if (state_next != state_reg) begin
         case (state_next)
            S_PWR_UP:    cnt_next = LD_VDD;
            S_LVDS_UP:   cnt_next = LD_LVDS;
            S_SYNC:      cnt_next = LD_SYNC;
            S_BL_DOWN:   cnt_next = LD_BL;
            S_LVDS_DOWN: cnt_next = LD_LOFF;
            S_COOL:      cnt_next = LD_COOL;
            default:     cnt_next = '0;
         endcase
      end else if (!cnt_zero) begin
         cnt_next = cnt_reg - CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Output decode from the next state, so outputs move on the same edge
   // as the state register.
   // ------------------------------------------------------------------
   always_comb begin
      vdd_next   = 1'b0;
      lvds_next  = 1'b0;
      blank_next = 1'b1;
      bl_next    = 1'b0;
      ready_next = 1'b0;
      case (state_next)
         S_PWR_UP: begin
            vdd_next = 1'b1;
         end
         S_LVDS_UP, S_SYNC, S_BL_DOWN: begin
            vdd_next  = 1'b1;
            lvds_next = 1'b1;
         end
         S_RUN: begin
            vdd_next   = 1'b1;
            lvds_next  = 1'b1;
            blank_next = 1'b0;
            bl_next    = 1'b1;
            ready_next = 1'b1;
         end
         S_LVDS_DOWN: begin
            vdd_next = 1'b1;
         end
         default: begin
            vdd_next = 1'b0;
         end
      endcase
   end

   assign bus.state        = state_reg;
   assign bus.panel_vdd_en = vdd_reg;
   assign bus.lvds_en      = lvds_reg;
   assign bus.blank        = blank_reg;
   assign bus.backlight_en = bl_reg;
   assign bus.ready        = ready_reg;
   assign bus.err          = err_reg;

endmodule
